serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 179 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder with a small control FSM. One addition A + B + Cin is
// performed LSB first, one bit per clock, through a single 1-bit full-adder
// cell fed by two operand shift registers and a carry flip-flop.
//
// Sequence (edge 0 = the edge that samples start in IDLE):
//   edge 0        : latch A, B, Cin; carry <= Cin; counter <= 0; -> RUN
//   edges 1..W    : add bit (edge-1), shift sum bit into working register
//   edge W        : -> DONE; publish S, Cout, ovf
//   edge W+1      : -> IDLE (start is ignored while in DONE)
// so a new start can be accepted every WIDTH+2 cycles.
//
// Ports
//   clk   : in  1      sole clock, rising edge
//   rst   : in  1      asynchronous, active-high reset
//   start : in  1      request a new addition (sampled only in IDLE)
//   abort : in  1      cancel an addition in progress (only honoured in RUN)
//   A, B  : in  WIDTH  operands, sampled together with start
//   Cin   : in  1      carry-in, sampled together with start
//   busy  : out 1      high while in RUN
//   done  : out 1      one-cycle pulse while in DONE
//   S     : out WIDTH  last completed sum (modulo 2^WIDTH)
//   Cout  : out 1      carry-out of the last completed sum
//   ovf   : out 1      signed overflow of the last completed sum
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    // Counter must hold 0..WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;        // operand A shift register (LSB = current bit)
    logic [WIDTH-1:0] r_b;        // operand B shift register
    logic [WIDTH-1:0] r_sum;      // working sum, filled from the MSB end
    logic             r_carry;    // carry into the bit currently processed
    logic [CW-1:0]    r_cnt;      // index of the bit currently processed

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum_bit;
    logic             w_carry_out;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic [WIDTH-1:0] w_sum_shifted;

    // -------------------------------------------------------------------------
    // Single 1-bit full-adder cell
    // -------------------------------------------------------------------------
    assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_out = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    // Sum bits enter at the MSB and move right, so after WIDTH shifts the
    // first (LSB) sum bit has arrived at position 0.
    assign w_sum_shifted = {w_sum_bit, r_sum[WIDTH-1:1]};

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_load   = (r_state == ST_IDLE) && start;   // abort ignored in IDLE
    // abort wins over both a normal step and completion.
    assign w_step   = (r_state == ST_RUN) && !abort;
    assign w_finish = w_step && w_last;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Serial datapath: operand shifters, working sum, carry and bit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a     <= A;
            r_b     <= B;
            r_sum   <= '0;
            r_carry <= Cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= w_sum_shifted;
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Result registers: written only on the RUN->DONE edge, held otherwise.
    // On the last bit r_carry is the carry into the MSB and w_carry_out the
    // carry out of it; their XOR is the signed overflow.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_finish) begin
            r_s    <= w_sum_shifted;
            r_cout <= w_carry_out;
            r_ovf  <= r_carry ^ w_carry_out;
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Stimulus process issues additions and pushes the expected {ovf,Cout,S}
// (computed with plain integer arithmetic) into a queue. A monitor process
// pops and compares on every done pulse, and otherwise checks that the
// published result holds. Timing of busy/done is checked by the stimulus.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    logic [W+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: true (WIDTH+1)-bit sum; signed overflow when both operands
    // share a sign and the truncated sum has the other sign.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        int unsigned full;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        full = int'(a) + int'(b) + int'(cin);
        s    = full[W-1:0];
        c    = full[W];
        v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {v, c, s};
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        logic [W+1:0] held;
        logic [W+1:0] exp;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = '0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp = exp_q.pop_front();
                    check("result", 32'({ovf, Cout, S}), 32'(exp));
                    held = exp;
                    txn++;
                    $display("txn %0d: S=%02h Cout=%0b ovf=%0b (exp S=%02h Cout=%0b ovf=%0b)",
                             txn, S, Cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
                end
            end else begin
                check("result_hold", 32'({ovf, Cout, S}), 32'(held));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    // Full operation with scoreboard push and busy/done timing checks.
    // Expects IDLE at the next falling edge; leaves the FSM in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int busy_n;
        int done_at;
        @(negedge clk);
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));   // abort with start in IDLE must not matter
        exp_q.push_back(model(a, b, cin));
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        Cin   = 1'($urandom);
        busy_n  = 0;
        done_at = -1;
        for (int k = 1; k <= 30 && done_at < 0; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) done_at = k;
        end
        check("busy_cycles", 32'(busy_n), 32'(W));
        check("done_latency", 32'(done_at), 32'(W + 1));
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'(0));
    endtask

    // Start an operation that will be cancelled (nothing pushed).
    task automatic start_only(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        check(name, 32'(n), 32'(0));
    endtask

    initial begin
        int ndone;
        int last_done;
        int cyc;

        // Reset state, forced asynchronously before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_outputs", 32'({busy, done, ovf, Cout, S}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed corner cases.
        do_op(8'hFF, 8'h01, 1'b0);
        check("ff_plus_01", 32'({ovf, Cout, S}), 32'h100);
        do_op(8'h7F, 8'h01, 1'b0);
        check("7f_plus_01", 32'({ovf, Cout, S}), 32'h280);
        do_op(8'h80, 8'h80, 1'b1);
        check("80_plus_80_c1", 32'({ovf, Cout, S}), 32'h301);

        // start held high: one result every W+2 cycles, operands scrambled
        // during RUN and restored before each IDLE sample.
        @(negedge clk);
        start = 1'b1;
        A     = 8'h12;
        B     = 8'h34;
        Cin   = 1'b0;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        ndone     = 0;
        last_done = -1;
        cyc       = 0;
        while (ndone < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (last_done >= 0) check("done_period", 32'(cyc - last_done), 32'(W + 2));
                last_done = cyc;
            end
            if (busy) begin
                A   = W'($urandom);
                B   = W'($urandom);
                Cin = 1'($urandom);
            end else begin
                A   = 8'h12;
                B   = 8'h34;
                Cin = 1'b0;
                if (!done) exp_q.push_back(model(8'h12, 8'h34, 1'b0));
            end
        end
        start = 1'b0;
        check("held_start_done_count", 32'(ndone), 32'(4));
        check("held_start_result", 32'({ovf, Cout, S}), 32'h046);

        // Abort sampled at edge 4.
        start_only(8'hAA, 8'h55, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort4_busy", 32'(busy), 32'(0));
        check("abort4_done", 32'(done), 32'(0));
        check("abort4_result", 32'({ovf, Cout, S}), 32'h046);
        expect_no_done("abort4_no_done", 12);

        // Abort coincident with the completing edge 8.
        start_only(8'hFF, 8'hFF, 1'b1);
        repeat (W - 1) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort8_busy", 32'(busy), 32'(0));
        check("abort8_done", 32'(done), 32'(0));
        check("abort8_result", 32'({ovf, Cout, S}), 32'h046);
        expect_no_done("abort8_no_done", 12);

        // Asynchronous reset in the middle of RUN.
        start_only(8'h0F, 8'hF0, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", 32'({busy, done, ovf, Cout, S}), 32'(0));
        #3 rst = 1'b0;
        expect_no_done("reset_no_done", 12);
        do_op(8'h21, 8'h43, 1'b1);
        check("after_reset_result", 32'({ovf, Cout, S}), 32'h065);

        // Random operands.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
